cache_2way_wb: RTL and testbench

- Parametrised successor to the direct-mapped write-through L1 data cache. Sits between the processor and main memory, using the same word-addressed processor interface and block-wide memory interface.
- Generalised to 2-way set-associative, with parametrised set count and block size.
- Write-back, write-allocate, with one LRU bit per set and a dirty bit per line.

---
 rtl/cache_2way_wb_if.sv | 31 +++
 rtl/cache_2way_wb.sv | 162 ++++++++++++++++
 tb/tb_cache_2way_wb.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_2way_wb_if.sv
// Processor and block-memory bus for the 2-way write-back cache.
// slave = cache side, master = processor + memory side.
interface cache_2way_wb_if #(
  parameter int ADDR_W = 30,
  parameter int OFF_W  = 2
);
  localparam int WORDS = 1 << OFF_W;

  logic                      proc_read;
  logic                      proc_write;
  logic [ADDR_W-1:0]         proc_addr;
  logic [31:0]               proc_wdata;
  logic [31:0]               proc_rdata;
  logic                      proc_stall;
  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-OFF_W-1:0]   mem_addr;
  logic [32*WORDS-1:0]       mem_wdata;
  logic [32*WORDS-1:0]       mem_rdata;
  logic                      mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_2way_wb.sv
// 2-way set-associative write-back/write-allocate L1 data cache, 0-cycle hits.
// Optional CACHE_PERF_CNT_EN adds hit_cnt/miss_cnt outputs.
module cache_2way_wb #(
  parameter int IDX_W  = 3,
  parameter int OFF_W  = 2,
  parameter int ADDR_W = 30
) (
  input  logic             clk,
  input  logic             proc_reset,
  cache_2way_wb_if.slave   bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt
`endif
);
  localparam int SETS   = 1 << IDX_W;
  localparam int WORDS  = 1 << OFF_W;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 32 * WORDS;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t                  state_reg;
  logic [1:0][SETS-1:0]    valid_reg;
  logic [1:0][SETS-1:0]    dirty_reg;
  logic [SETS-1:0]         lru_reg;
  logic                    victim_reg;
  logic                    fill_done_reg;

  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        req_idx;
  logic [OFF_W-1:0]        req_off;
  logic                    req;
  logic [TAG_W-1:0]        way_tag [2];
  logic [LINE_W-1:0]       way_line [2];
  logic [1:0]              hit_w;
  logic                    hit;
  logic                    hit_way;
  logic [LINE_W-1:0]       hit_line;
  logic [LINE_W-1:0]       line_wr;
  logic                    write_hit;
  logic                    fill;
  logic                    victim_next;

  assign req_tag  = bus.proc_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = bus.proc_addr[OFF_W +: IDX_W];
  assign req_off  = bus.proc_addr[OFF_W-1:0];
  assign req      = bus.proc_read | bus.proc_write;

  assign hit       = |hit_w;
  assign hit_way   = hit_w[1];
  assign hit_line  = way_line[hit_way];
  assign write_hit = (state_reg == COMPARE) && bus.proc_write && hit;
  assign fill      = (state_reg == ALLOCATE) && bus.mem_ready;

  // A fill replaces the whole line; a write hit merges one word into the hit line.
  always_comb begin
    line_wr = hit_line;
    line_wr[{req_off, 5'b0} +: 32] = bus.proc_wdata;
    if (state_reg == ALLOCATE)
      line_wr = bus.mem_rdata;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      logic [TAG_W-1:0]  tag_arr  [SETS];
      logic [LINE_W-1:0] data_arr [SETS];
      logic              we;
      logic              fill_we;

      assign fill_we      = fill && (victim_reg == 1'(gi));
      assign we           = (write_hit && hit_w[gi]) || fill_we;
      assign way_tag[gi]  = tag_arr[req_idx];
      assign way_line[gi] = data_arr[req_idx];
      assign hit_w[gi]    = valid_reg[gi][req_idx] && (tag_arr[req_idx] == req_tag);

      always_ff @(posedge clk) begin
        if (!proc_reset && we)
          data_arr[req_idx] <= line_wr;
        if (!proc_reset && fill_we)
          tag_arr[req_idx] <= req_tag;
      end
    end
  endgenerate

  always_comb begin
    victim_next = lru_reg[req_idx];
    if (!valid_reg[0][req_idx])
      victim_next = 1'b0;
    else if (!valid_reg[1][req_idx])
      victim_next = 1'b1;
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;
  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_reg     <= COMPARE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      lru_reg       <= '0;
      victim_reg    <= 1'b0;
      fill_done_reg <= 1'b0;
`ifdef CACHE_PERF_CNT_EN
      hit_cnt_reg   <= '0;
      miss_cnt_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        COMPARE: begin
          fill_done_reg <= 1'b0;
          if (req && hit) begin
            lru_reg[req_idx] <= ~hit_way;
            if (bus.proc_write)
              dirty_reg[hit_way][req_idx] <= 1'b1;
`ifdef CACHE_PERF_CNT_EN
            // The hit that completes a miss is not a fresh hit.
            if (!fill_done_reg)
              hit_cnt_reg <= hit_cnt_reg + 32'd1;
`endif
          end else if (req) begin
            victim_reg <= victim_next;
            if (valid_reg[victim_next][req_idx] && dirty_reg[victim_next][req_idx])
              state_reg <= WRITEBACK;
            else
              state_reg <= ALLOCATE;
`ifdef CACHE_PERF_CNT_EN
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
`endif
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready)
            state_reg <= ALLOCATE;
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            valid_reg[victim_reg][req_idx] <= 1'b1;
            dirty_reg[victim_reg][req_idx] <= 1'b0;
            fill_done_reg                  <= 1'b1;
            state_reg                      <= COMPARE;
          end
        end
        default: state_reg <= COMPARE;
      endcase
    end
  end

  assign bus.proc_stall = (state_reg != COMPARE) || (req && !hit);
  assign bus.proc_rdata = hit_line[{req_off, 5'b0} +: 32];
  assign bus.mem_write  = (state_reg == WRITEBACK);
  assign bus.mem_read   = (state_reg == ALLOCATE);
  assign bus.mem_addr   = (state_reg == WRITEBACK) ? {way_tag[victim_reg], req_idx}
                                                   : {req_tag, req_idx};
  assign bus.mem_wdata  = way_line[victim_reg];
endmodule

// File: tb/tb_cache_2way_wb.sv
// Scoreboard bench for cache_2way_wb: stimulus queues expected events, a monitor
// pops and checks them as the DUT completes requests or raises memory strobes.
module tb_cache_2way_wb;
  localparam int EV_RD  = 0;
  localparam int EV_WR  = 1;
  localparam int EV_MRD = 2;
  localparam int EV_MWR = 3;
  localparam int MEM_LAT = 3;

  typedef struct {
    int           kind;
    logic [27:0]  addr;
    logic [31:0]  data;
    logic [127:0] blk;
  } exp_t;

  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  cache_2way_wb_if #(.ADDR_W(30), .OFF_W(2)) bus ();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  cache_2way_wb #(.IDX_W(3), .OFF_W(2), .ADDR_W(30)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus.slave)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  function automatic void push(int kind, logic [27:0] addr, logic [31:0] data, logic [127:0] blk);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.blk = blk;
    exp_q.push_back(e);
  endfunction

  // Memory model: block 1 has a hand-chosen pattern, others word k = B000_0000 | {blk,k}.
  logic [127:0] mem_model [logic [27:0]];
  int mcnt;

  function automatic logic [127:0] blk_init(logic [27:0] a);
    logic [127:0] b;
    if (a == 28'h1)
      return {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 4; k++)
      b[32*k +: 32] = 32'hB000_0000 | {a, 4'(k)};
    return b;
  endfunction

  always @(negedge clk) begin
    if (proc_reset || !(bus.mem_read || bus.mem_write)) begin
      mcnt = 0;
      bus.mem_ready = 1'b0;
    end else begin
      if (bus.mem_ready) mcnt = 1;
      else               mcnt++;
      bus.mem_ready = (mcnt == MEM_LAT);
      if (bus.mem_ready) begin
        if (bus.mem_write)
          mem_model[bus.mem_addr] = bus.mem_wdata;
        else
          bus.mem_rdata = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr]
                                                         : blk_init(bus.mem_addr);
      end
    end
  end

  task automatic got(int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d, required none", kind);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 128'(kind), 128'(e.kind));
    if (kind == e.kind) begin
      case (kind)
        EV_RD:  check("proc_rdata", 128'(bus.proc_rdata), 128'(e.data));
        EV_MRD: check("mem_read_addr", 128'(bus.mem_addr), 128'(e.addr));
        EV_MWR: begin
          check("mem_write_addr", 128'(bus.mem_addr), 128'(e.addr));
          check("mem_wdata", bus.mem_wdata, e.blk);
        end
        default: ;
      endcase
    end
  endtask

  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (proc_reset) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (bus.mem_write && !prev_wr) got(EV_MWR);
      if (bus.mem_read && !prev_rd)  got(EV_MRD);
      if ((bus.proc_read || bus.proc_write) && !bus.proc_stall)
        got(bus.proc_write ? EV_WR : EV_RD);
      prev_rd = bus.mem_read;
      prev_wr = bus.mem_write;
    end
  end

  task automatic do_req(logic rd, logic wr, logic [29:0] addr, logic [31:0] wd, int exp_lat);
    int cyc = 0;
    bit done = 0;
    @(posedge clk); #1;
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wd;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (!bus.proc_stall) done = 1;
      else cyc++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout addr=%0h: got stall after %0d cycles, required completion", addr, cyc);
    end else begin
      check("latency", 128'(cyc), 128'(exp_lat));
    end
    @(posedge clk); #1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    proc_reset     = 1'b1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
    @(negedge clk);
    check("reset_stall", 128'(bus.proc_stall), 128'(0));
    check("reset_mem_read", 128'(bus.mem_read), 128'(0));
    check("reset_mem_write", 128'(bus.mem_write), 128'(0));

    // 1: cold read miss, fill block 1
    push(EV_MRD, 28'h1, 0, 0);
    push(EV_RD, 0, 32'h1111_1111, 0);
    do_req(1, 0, 30'h4, 0, 4);
    // 2: hit on word2 of the same block
    push(EV_RD, 0, 32'h3333_3333, 0);
    do_req(1, 0, 30'h6, 0, 0);
    // 3: write hit then read back
    push(EV_WR, 0, 0, 0);
    do_req(0, 1, 30'h5, 32'hCAFE_F00D, 0);
    push(EV_RD, 0, 32'hCAFE_F00D, 0);
    do_req(1, 0, 30'h5, 0, 0);
    // 4a: same set, new tag -> way1, no writeback
    push(EV_MRD, 28'h41, 0, 0);
    push(EV_RD, 0, 32'hB000_0410, 0);
    do_req(1, 0, 30'h104, 0, 4);
    // 4b: third tag evicts dirty way0
    push(EV_MWR, 28'h1, 0, {32'h4444_4444, 32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111});
    push(EV_MRD, 28'h81, 0, 0);
    push(EV_RD, 0, 32'hB000_0810, 0);
    do_req(1, 0, 30'h204, 0, 7);
`ifdef CACHE_PERF_CNT_EN
    check("hit_cnt", 128'(hit_cnt), 128'(3));
    check("miss_cnt", 128'(miss_cnt), 128'(3));
`endif
    // written-back word must come back from memory (evicts clean way1)
    push(EV_MRD, 28'h1, 0, 0);
    push(EV_RD, 0, 32'hCAFE_F00D, 0);
    do_req(1, 0, 30'h5, 0, 4);

    // 5: reset in the middle of ALLOCATE
    push(EV_MRD, 28'hC1, 0, 0);
    @(posedge clk); #1;
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h304;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.mem_read && w < 20);
    check("alloc_reached", 128'(bus.mem_read), 128'(1));
    @(posedge clk); #1;
    proc_reset    = 1'b1;
    bus.proc_read = 1'b0;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    @(negedge clk);
    check("abort_mem_read", 128'(bus.mem_read), 128'(0));
    check("abort_mem_write", 128'(bus.mem_write), 128'(0));
    check("abort_stall", 128'(bus.proc_stall), 128'(0));
    push(EV_MRD, 28'h41, 0, 0);
    push(EV_RD, 0, 32'hB000_0410, 0);
    do_req(1, 0, 30'h104, 0, 4);

    // 6: read+write together is a write
    push(EV_MRD, 28'h2, 0, 0);
    push(EV_WR, 0, 0, 0);
    do_req(1, 1, 30'h8, 32'h5A5A_5A5A, 4);
    push(EV_RD, 0, 32'h5A5A_5A5A, 0);
    do_req(1, 0, 30'h8, 0, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
